// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: one WIDTH/STAGES-bit lookahead slice per stage,
// carry handed forward through stage registers, whole-pipe valid/ready stall.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operandA,
  input  logic [WIDTH-1:0] i_operandB,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int DQ  = (STAGES > 1) ? STAGES - 1 : 1;

  generate
    if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_adder: STAGES must be 1..8 and divide WIDTH");
    end
  endgenerate

  logic [STAGES-1:0] valid_q, cy_q, sub_q;
  logic              msb_c_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  a_q   [DQ];
  logic [WIDTH-1:0]  b_q   [DQ];

  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  res_in [STAGES];
  logic [WIDTH-1:0]  res_nx [STAGES];
  logic [STAGES-1:0] valid_in, cin_in, sub_in, cy_nx;
  logic              msb_c_nx;
  logic              adv;

  // Kogge-Stone prefix over one segment; returns carries c[0]=cin .. c[SEG]=carry-out.
  function automatic logic [SEG:0] cla(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                       input logic cin);
    logic [SEG-1:0] gg, pp, gn, pn;
    logic [SEG:0]   c;
    gg = a & b;
    pp = a ^ b;
    for (int unsigned d = 1; d < SEG; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int unsigned i = d; i < SEG; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    c[0] = cin;
    for (int unsigned i = 0; i < SEG; i++) c[i+1] = gg[i] | (pp[i] & cin);
    return c;
  endfunction

  assign adv = ~valid_q[STAGES-1] | i_ready;

  always_comb begin
    logic [SEG-1:0] as, bs;
    logic [SEG:0]   c;
    msb_c_nx = 1'b0;
    cy_nx    = '0;
    valid_in = '0;
    cin_in   = '0;
    sub_in   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Subtract folds into add: A + ~B + ~borrow_in.
        a_in[k]     = i_operandA;
        b_in[k]     = i_sub ? ~i_operandB : i_operandB;
        res_in[k]   = '0;
        valid_in[k] = i_valid;
        cin_in[k]   = i_carry ^ i_sub;
        sub_in[k]   = i_sub;
      end else begin
        a_in[k]     = a_q[k-1];
        b_in[k]     = b_q[k-1];
        res_in[k]   = res_q[k-1];
        valid_in[k] = valid_q[k-1];
        cin_in[k]   = cy_q[k-1];
        sub_in[k]   = sub_q[k-1];
      end
      as = a_in[k][k*SEG +: SEG];
      bs = b_in[k][k*SEG +: SEG];
      c  = cla(as, bs, cin_in[k]);
      res_nx[k] = res_in[k];
      res_nx[k][k*SEG +: SEG] = as ^ bs ^ c[SEG-1:0];
      cy_nx[k] = c[SEG];
      if (k == STAGES - 1) msb_c_nx = c[SEG-1];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= '0;
      cy_q    <= '0;
      sub_q   <= '0;
      msb_c_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) res_q[k] <= '0;
      for (int unsigned k = 0; k < DQ; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_in;
      cy_q    <= cy_nx;
      sub_q   <= sub_in;
      msb_c_q <= msb_c_nx;
      res_q   <= res_nx;
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
      end
    end
  end

  assign o_ready    = adv;
  assign o_valid    = valid_q[STAGES-1];
  assign o_result   = res_q[STAGES-1];
  assign o_carry    = cy_q[STAGES-1] ^ sub_q[STAGES-1];
  assign o_overflow = msb_c_q ^ cy_q[STAGES-1];
  // Gated with valid so the flag reads 0 while the pipe is in reset or empty.
  assign o_zero     = valid_q[STAGES-1] & ~|res_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations share one input stream; each has a
// scoreboard fed from an arithmetic reference, plus directed table and corner sequences.
module tb_pipelined_adder;

  localparam int N_DUT = 4;
  localparam int WID [N_DUT] = '{32, 64, 64, 64};
  localparam int STG [N_DUT] = '{2, 1, 4, 8};

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        ov;
    logic        z;
    int          acc;
    bit          lat_ok;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] res;
    logic        c, ov, z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rdy_in, cin, sub;
  logic [63:0] opa, opb;

  logic [N_DUT-1:0] dv, drdy, dc, dov, dz;
  logic [31:0]      res0;
  logic [63:0]      res1, res2, res3;
  logic [63:0]      dres [N_DUT];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b1;
  exp_t exp_q [N_DUT][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dres[0] = {32'b0, res0};
    dres[1] = res1;
    dres[2] = res2;
    dres[3] = res3;
  end

  pipelined_adder #(.WIDTH(32), .STAGES(2)) u_dut0 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(drdy[0]),
    .i_operandA(opa[31:0]), .i_operandB(opb[31:0]), .i_carry(cin), .i_sub(sub),
    .o_valid(dv[0]), .i_ready(rdy_in), .o_result(res0), .o_carry(dc[0]),
    .o_overflow(dov[0]), .o_zero(dz[0]));

  pipelined_adder #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(drdy[1]),
    .i_operandA(opa), .i_operandB(opb), .i_carry(cin), .i_sub(sub),
    .o_valid(dv[1]), .i_ready(rdy_in), .o_result(res1), .o_carry(dc[1]),
    .o_overflow(dov[1]), .o_zero(dz[1]));

  pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(drdy[2]),
    .i_operandA(opa), .i_operandB(opb), .i_carry(cin), .i_sub(sub),
    .o_valid(dv[2]), .i_ready(rdy_in), .o_result(res2), .o_carry(dc[2]),
    .o_overflow(dov[2]), .o_zero(dz[2]));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut3 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(drdy[3]),
    .i_operandA(opa), .i_operandB(opb), .i_carry(cin), .i_sub(sub),
    .o_valid(dv[3]), .i_ready(rdy_in), .o_result(res3), .o_carry(dc[3]),
    .o_overflow(dov[3]), .o_zero(dz[3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Exact-integer reference: unsigned and signed results taken in 66 bits, then classified.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb, input int w);
    exp_t r;
    logic        [65:0] full, half, ua, ub, u;
    logic signed [65:0] sa, sb_s, s;
    full = 66'd1 << w;
    half = full >> 1;
    ua = {2'b0, a} & (full - 66'd1);
    ub = {2'b0, b} & (full - 66'd1);
    sa = $signed(ua);
    sb_s = $signed(ub);
    if (ua[w-1]) sa = sa - $signed(full);
    if (ub[w-1]) sb_s = sb_s - $signed(full);
    if (!sb) begin
      u = ua + ub + 66'(ci);
      s = sa + sb_s + $signed({65'b0, ci});
      r.c = (u >= full);
    end else begin
      u = ua - ub - 66'(ci);
      s = sa - sb_s - $signed({65'b0, ci});
      r.c = (ua < ub + 66'(ci));
    end
    r.ov = (s >= $signed(half)) || (s < -$signed(half));
    r.res = 64'(u & (full - 66'd1));
    r.z = (r.res == 64'd0);
    r.acc = 0;
    r.lat_ok = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < N_DUT; d++) exp_q[d].delete();
    end else begin
      for (int d = 0; d < N_DUT; d++) begin
        if (dv[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL d%0d_spurious actual=valid required=no_output", d);
          end else begin
            mon_e = exp_q[d][0];
            chk($sformatf("d%0d_res", d), dres[d], mon_e.res);
            chk($sformatf("d%0d_carry", d), 64'(dc[d]), 64'(mon_e.c));
            chk($sformatf("d%0d_ovf", d), 64'(dov[d]), 64'(mon_e.ov));
            chk($sformatf("d%0d_zero", d), 64'(dz[d]), 64'(mon_e.z));
            if (mon_e.lat_ok && lat_chk && rdy_in)
              chk($sformatf("d%0d_latency", d), 64'(cyc - mon_e.acc), 64'(STG[d]));
            if (rdy_in) void'(exp_q[d].pop_front());
          end
        end
        if (valid && drdy[d]) begin
          mon_e = model(opa, opb, cin, sub, WID[d]);
          mon_e.acc = cyc;
          mon_e.lat_ok = lat_chk;
          exp_q[d].push_back(mon_e);
        end
      end
    end
  end

  // Caller must be at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
    opa = x; opb = y; cin = ci; sub = sb; valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (drdy[0]) begin
        @(posedge clk); #1;
        valid = 1'b0;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL send_timeout actual=not_accepted required=accepted");
    valid = 1'b0;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom % 8)
      0: return 64'd0;
      1: return '1;
      2: return 64'h0000_0000_8000_0000;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  vec_t        vecs [10];
  logic [63:0] got [$];
  logic [63:0] prev_res;
  bit          take, prev_v, prev_stall;
  int          idx, sent;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0};
    vecs[2] = '{32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 1, 0, 0};
    vecs[3] = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 0, 1, 0};
    vecs[4] = '{32'h00000000, 32'h00000000, 1, 0, 32'h00000001, 0, 0, 0};
    vecs[5] = '{32'h00000000, 32'h00000000, 1, 1, 32'hFFFFFFFF, 1, 0, 0};
    vecs[6] = '{32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 0, 0, 1};
    vecs[7] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1};
    vecs[8] = '{32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0, 0};
    vecs[9] = '{32'h00010000, 32'h00000001, 0, 1, 32'h0000FFFF, 0, 0, 0};

    rst_n = 1'b0; valid = 1'b0; rdy_in = 1'b1; cin = 1'b0; sub = 1'b0;
    opa = '0; opb = '0;
    #3;
    for (int d = 0; d < N_DUT; d++) begin
      chk($sformatf("rst_valid%0d", d), 64'(dv[d]), 64'd0);
      chk($sformatf("rst_ready%0d", d), 64'(drdy[d]), 64'd1);
      chk($sformatf("rst_res%0d", d), dres[d], 64'd0);
      chk($sformatf("rst_flags%0d", d), 64'({dc[d], dov[d], dz[d]}), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send({32'b0, vecs[i].a}, {32'b0, vecs[i].b}, vecs[i].ci, vecs[i].sb);
      @(negedge clk);
      chk($sformatf("vec%0d_early", i), 64'(dv[0]), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(dv[0]), 64'd1);
      chk($sformatf("vec%0d_res", i), dres[0], {32'b0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), 64'({dc[0], dov[0], dz[0]}),
          64'({vecs[i].c, vecs[i].ov, vecs[i].z}));
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      opa = pick(); opb = pick(); cin = 1'($urandom); sub = 1'($urandom); valid = 1'b1;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    lat_chk = 1'b0;
    idx = 0; take = 1'b0; prev_v = 1'b0; prev_stall = 1'b0; prev_res = '0;
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      if (take) idx++;
      valid = (idx < 4);
      opa = 64'(idx + 1); opb = 64'(idx + 1); cin = 1'b0; sub = 1'b0;
      rdy_in = !(t >= 3 && t <= 5);
      @(negedge clk);
      take = valid && drdy[0];
      if (dv[0] && !rdy_in) begin
        chk($sformatf("stall_ready_t%0d", t), 64'(drdy[0]), 64'd0);
        if (prev_v && prev_stall) chk($sformatf("stall_hold_t%0d", t), dres[0], prev_res);
      end
      if (dv[0] && rdy_in) got.push_back(dres[0]);
      prev_v = dv[0]; prev_stall = !rdy_in; prev_res = dres[0];
    end
    chk("stall_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("stall_order%0d", i), got[i], 64'(2 * (i + 1)));
    @(posedge clk); #1;
    valid = 1'b0; rdy_in = 1'b1;
    repeat (12) @(posedge clk);
    #1 lat_chk = 1'b1;

    send(64'd7, 64'd8, 1'b0, 1'b0);
    send(64'd9, 64'd1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      chk($sformatf("midrst_valid%0d", d), 64'(dv[d]), 64'd0);
      chk($sformatf("midrst_ready%0d", d), 64'(drdy[d]), 64'd1);
      chk($sformatf("midrst_res%0d", d), dres[d], 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_c%0d", i), 64'(dv), 64'd0);
    end
    @(posedge clk); #1;
    send(64'd10, 64'd20, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_after_rst_early", 64'(dv[0]), 64'd0);
    @(negedge clk);
    chk("lat_after_rst_valid", 64'(dv[0]), 64'd1);
    chk("lat_after_rst_res", dres[0], 64'd30);
    repeat (12) @(posedge clk);
    #1;

    lat_chk = 1'b0;
    sent = 0; take = 1'b0; valid = 1'b0;
    while (sent < 300) begin
      @(posedge clk); #1;
      if (take || !valid) begin
        valid = ($urandom % 5) != 0;
        if (valid) begin
          opa = pick(); opb = pick(); cin = 1'($urandom); sub = 1'($urandom);
          sent++;
        end
      end
      rdy_in = ($urandom % 4) != 0;
      @(negedge clk);
      take = valid && drdy[0];
    end
    @(posedge clk); #1;
    rdy_in = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int d = 0; d < N_DUT; d++)
      chk($sformatf("drained%0d", d), 64'(exp_q[d].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, number of pipeline stages; legal range 1..8.
REQ-003 The block SHALL have port i_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_valid  input  1  input operation valid.
REQ-006 The block SHALL have port o_ready  output  1  block accepts an operation this cycle.
REQ-007 The block SHALL have port i_operandA  input  WIDTH  operand A.
REQ-008 The block SHALL have port i_operandB  input  WIDTH  operand B.
REQ-009 The block SHALL have port i_carry  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 The block SHALL have port i_sub  input  1  0 = add, 1 = subtract.
REQ-011 The block SHALL have port o_valid  output  1  result valid.
REQ-012 The block SHALL have port i_ready  input  1  downstream accepts result.
REQ-013 The block SHALL have port o_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 The block SHALL have port o_carry  output  1  carry-out (add) or borrow-out (subtract).
REQ-015 The block SHALL have port o_overflow  output  1  signed two's-complement overflow.
REQ-016 The block SHALL have port o_zero  output  1  o_result equals zero.

Function
REQ-017 Elaboration SHALL fail if WIDTH mod STAGES != 0 or STAGES outside 1..8.
REQ-018 Operands SHALL be split into STAGES segments of WIDTH/STAGES bits; stage k computes segment k with in-stage carry-lookahead, taking carry from stage k-1's register.
REQ-019 Unprocessed upper operand segments SHALL be delayed and finished lower result segments SHALL be skewed so all segments of one operation emerge together.
REQ-020 Add: result = A + B + i_carry; o_carry = unsigned carry out of bit WIDTH-1.
REQ-021 Subtract: result = A - B - i_carry, computed as A + ~B + ~i_carry; o_carry = inverted internal carry-out, i.e. 1 when A < B + i_carry unsigned.
REQ-022 o_overflow SHALL equal internal carry into bit WIDTH-1 XOR internal carry out of bit WIDTH-1, both modes.
REQ-023 o_zero SHALL be 1 exactly when o_result == 0, independent of o_carry.
REQ-024 Latency SHALL be STAGES cycles from accepted input (i_valid & o_ready at edge) to o_valid, with no backpressure.
REQ-025 Throughput SHALL be one operation per cycle; o_ready = ~o_valid | i_ready (whole-pipe stall, combinational).
REQ-026 While o_valid=1 and i_ready=0, all stage registers and outputs SHALL hold; no operation lost, duplicated or reordered.
REQ-027 A stage holding no valid operation SHALL be fillable (bubble) only via the global advance; bubbles SHALL propagate with valid=0.
REQ-028 Simultaneous input accept and output drain in one cycle SHALL both occur.
REQ-029 Outputs o_result/o_carry/o_overflow/o_zero SHALL be don't-care when o_valid=0, but SHALL be stable while o_valid=1 and stalled.
REQ-030 STAGES=1 SHALL give a single registered full-width lookahead adder, latency 1.

Reset
REQ-031 i_reset low SHALL immediately clear all stage valid bits; o_valid=0, o_result=0, o_carry=0, o_overflow=0, o_zero=0.
REQ-032 Reset mid-operation SHALL discard every in-flight operation; none emerges after release.
REQ-033 o_ready SHALL be 1 during and after reset (pipe empty).

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-034 add 0xFFFFFFFF+0x00000001, cin 0 -> after 2 cycles result 0x00000000, carry 1, overflow 0, zero 1.
REQ-035 add 0x7FFFFFFF+0x00000001, cin 0 -> result 0x80000000, carry 0, overflow 1, zero 0.
REQ-036 sub 5-7, borrow 0 -> result 0xFFFFFFFE, carry(borrow) 1, overflow 0; sub 0x80000000-1 -> 0x7FFFFFFF, borrow 0, overflow 1.
REQ-037 4 back-to-back adds (1+1, 2+2, 3+3, 4+4), i_ready low cycles 3..5 -> results 2,4,6,8 in order, outputs held during stall, o_ready low while stalled.
REQ-038 2 ops in flight, reset pulsed low -> o_valid 0 asynchronously, no result appears after release; next op 10+20 -> 30 with latency 2.
REQ-039 Repeat REQ-034..037 with STAGES=1, 4, 8 and WIDTH=64; random A/B/cin/sub compared against full-width reference model, latency = STAGES.
